// File: rtl/sdc_cmd_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------------------+
// | sdc_cmd_arbiter: round-robin sharing of one SD SPI command engine by NREQ requesters |
// | Optional engine watchdog: define SDC_ARB_TIMEOUT_EN.          Revision: 1.0          |
// +------------------------------------------------------------------------------------+
module sdc_cmd_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 2_700_000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NREQ-1:0]     i_req,
  input  logic [NREQ*8-1:0]   i_cmd,
  input  logic [NREQ*32-1:0]  i_arg,
  input  logic [NREQ*8-1:0]   i_crc,
  output logic [NREQ-1:0]     o_gnt,
  output logic [NREQ-1:0]     o_done,
  output logic [7:0]          o_response,
  output logic                o_timeout,
  output logic [7:0]          o_eng_cmd,
  output logic [31:0]         o_eng_arg,
  output logic [7:0]          o_eng_crc,
  output logic                o_eng_we,
  input  logic                i_eng_done,
  input  logic [7:0]          i_eng_response
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [7:0]        response_q, response_d;
  logic              timeout_q, timeout_d;
  logic              eng_we_q, eng_we_d;
  logic [7:0]        eng_cmd_q, eng_cmd_d;
  logic [31:0]       eng_arg_q, eng_arg_d;
  logic [7:0]        eng_crc_q, eng_crc_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [IDX_W-1:0]  widx_q, widx_d;

  logic              found_hi, found_lo;
  logic [IDX_W-1:0]  idx_hi, idx_lo, win_idx;
  logic [7:0]        win_cmd, win_crc;
  logic [31:0]       win_arg;
  logic              expired;

  // Lowest request above the last winner, else wrap to the lowest request overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        found_lo = 1'b1;
        idx_lo   = IDX_W'(i);
        if (IDX_W'(i) > last_q) begin
          found_hi = 1'b1;
          idx_hi   = IDX_W'(i);
        end
      end
    end
    win_idx = found_hi ? idx_hi : idx_lo;
    win_cmd = '0;
    win_arg = '0;
    win_crc = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDX_W'(i) == win_idx) begin
        win_cmd = i_cmd[i*8 +: 8];
        win_arg = i_arg[i*32 +: 32];
        win_crc = i_crc[i*8 +: 8];
      end
    end
  end

`ifdef SDC_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT) > 22) ? $clog2(TIMEOUT) : 22;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign expired        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    response_d = response_q;
    timeout_d  = 1'b0;
    eng_we_d   = 1'b0;
    eng_cmd_d  = eng_cmd_q;
    eng_arg_d  = eng_arg_q;
    eng_crc_d  = eng_crc_q;
    last_d     = last_q;
    widx_d     = widx_q;
    case (state_q)
      ST_IDLE: begin
        if (found_lo) begin
          gnt_d     = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
          eng_cmd_d = win_cmd;
          eng_arg_d = win_arg;
          eng_crc_d = win_crc;
          eng_we_d  = 1'b1;
          widx_d    = win_idx;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A done seen during the strobe cycle belongs to an earlier command.
        if (i_eng_done && !eng_we_q) begin
          response_d = i_eng_response;
          done_d     = gnt_q;
          last_d     = widx_q;
          state_d    = ST_DONE;
        end else if (expired) begin
          response_d = 8'hFF;
          done_d     = gnt_q;
          timeout_d  = 1'b1;
          last_d     = widx_q;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      response_q <= 8'hFF;
      timeout_q  <= 1'b0;
      eng_we_q   <= 1'b0;
      eng_cmd_q  <= 8'hFF;
      eng_arg_q  <= 32'hFFFF_FFFF;
      eng_crc_q  <= 8'hFF;
      last_q     <= IDX_W'(NREQ - 1);
      widx_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      response_q <= response_d;
      timeout_q  <= timeout_d;
      eng_we_q   <= eng_we_d;
      eng_cmd_q  <= eng_cmd_d;
      eng_arg_q  <= eng_arg_d;
      eng_crc_q  <= eng_crc_d;
      last_q     <= last_d;
      widx_q     <= widx_d;
    end
  end

  assign o_gnt      = gnt_q;
  assign o_done     = done_q;
  assign o_response = response_q;
  assign o_timeout  = timeout_q;
  assign o_eng_we   = eng_we_q;
  assign o_eng_cmd  = eng_cmd_q;
  assign o_eng_arg  = eng_arg_q;
  assign o_eng_crc  = eng_crc_q;

endmodule
`default_nettype wire

// File: tb/tb_sdc_cmd_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------------------+
// | tb_sdc_cmd_arbiter: bench for sdc_cmd_arbiter with two requesters.   Revision: 1.0  |
// +------------------------------------------------------------------------------------+
module tb_sdc_cmd_arbiter;

  localparam int NREQ       = 2;
  localparam int TB_TIMEOUT = 100;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    i_req;
  logic [NREQ*8-1:0]  i_cmd;
  logic [NREQ*32-1:0] i_arg;
  logic [NREQ*8-1:0]  i_crc;
  logic [NREQ-1:0]    o_gnt;
  logic [NREQ-1:0]    o_done;
  logic [7:0]         o_response;
  logic               o_timeout;
  logic [7:0]         o_eng_cmd;
  logic [31:0]        o_eng_arg;
  logic [7:0]         o_eng_crc;
  logic               o_eng_we;
  logic               i_eng_done;
  logic [7:0]         i_eng_response;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sdc_cmd_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req          (i_req),
    .i_cmd          (i_cmd),
    .i_arg          (i_arg),
    .i_crc          (i_crc),
    .o_gnt          (o_gnt),
    .o_done         (o_done),
    .o_response     (o_response),
    .o_timeout      (o_timeout),
    .o_eng_cmd      (o_eng_cmd),
    .o_eng_arg      (o_eng_arg),
    .o_eng_crc      (o_eng_crc),
    .o_eng_we       (o_eng_we),
    .i_eng_done     (i_eng_done),
    .i_eng_response (i_eng_response)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_slices(input logic [7:0] c0, input logic [31:0] a0, input logic [7:0] r0,
                            input logic [7:0] c1, input logic [31:0] a1, input logic [7:0] r1);
    i_cmd = {c1, c0};
    i_arg = {a1, a0};
    i_crc = {r1, r0};
  endtask

  // Issue one command from IDLE and complete it with an engine reply 'delay' cycles after the strobe.
  task automatic do_cmd(input string tag, input logic [1:0] req, input logic [1:0] mid_req,
                        input logic [1:0] exp_gnt, input logic [7:0] exp_cmd,
                        input logic [31:0] exp_arg, input logic [7:0] exp_crc,
                        input int delay, input logic [7:0] resp, input bit stale);
    logic seen_done;
    i_req = req;
    @(negedge clk);
    check({tag, "_we"},  64'(o_eng_we),  64'(1));
    check({tag, "_gnt"}, 64'(o_gnt),     64'(exp_gnt));
    check({tag, "_cmd"}, 64'(o_eng_cmd), 64'(exp_cmd));
    check({tag, "_arg"}, 64'(o_eng_arg), 64'(exp_arg));
    check({tag, "_crc"}, 64'(o_eng_crc), 64'(exp_crc));
    seen_done = 1'b0;
    if (stale) begin
      i_eng_done     = 1'b1;
      i_eng_response = 8'hAA;
    end
    for (int i = 1; i < delay; i++) begin
      @(negedge clk);
      i_eng_done = 1'b0;
      if (o_done != '0) seen_done = 1'b1;
      if (i == 1) check({tag, "_we_drop"}, 64'(o_eng_we), 64'(0));
      if (i == delay / 2) i_req = mid_req;
    end
    check({tag, "_early_done"}, 64'(seen_done), 64'(0));
    check({tag, "_gnt_held"}, 64'(o_gnt), 64'(exp_gnt));
    i_eng_done     = 1'b1;
    i_eng_response = resp;
    @(negedge clk);
    i_eng_done = 1'b0;
    check({tag, "_done"},    64'(o_done),     64'(exp_gnt));
    check({tag, "_resp"},    64'(o_response), 64'(resp));
    check({tag, "_timeout"}, 64'(o_timeout),  64'(0));
    @(negedge clk);
    check({tag, "_done_end"}, 64'(o_done), 64'(0));
    check({tag, "_gnt_end"},  64'(o_gnt),  64'(0));
  endtask

  initial begin
    rst            = 1'b1;
    i_req          = '0;
    i_eng_done     = 1'b0;
    i_eng_response = 8'h00;
    set_slices(8'h00, 32'h0, 8'h00, 8'h00, 32'h0, 8'h00);
    repeat (2) @(negedge clk);

    check("rst_gnt",  64'(o_gnt),      64'(0));
    check("rst_done", 64'(o_done),     64'(0));
    check("rst_resp", 64'(o_response), 64'(8'hFF));
    check("rst_to",   64'(o_timeout),  64'(0));
    check("rst_we",   64'(o_eng_we),   64'(0));
    check("rst_cmd",  64'(o_eng_cmd),  64'(8'hFF));
    check("rst_arg",  64'(o_eng_arg),  64'(32'hFFFF_FFFF));
    check("rst_crc",  64'(o_eng_crc),  64'(8'hFF));
    rst = 1'b0;

    // Basic CMD0 from requester 0
    set_slices(8'h40, 32'h0, 8'h95, 8'h48, 32'h0000_01AA, 8'h87);
    do_cmd("t1", 2'b01, 2'b01, 2'b01, 8'h40, 32'h0, 8'h95, 20, 8'h01, 1'b0);
    i_req = 2'b00;

    // Engine done while idle, then a stale done in the strobe cycle
    i_eng_done     = 1'b1;
    i_eng_response = 8'h55;
    @(negedge clk);
    i_eng_done = 1'b0;
    check("idle_done", 64'(o_done),   64'(0));
    check("idle_we",   64'(o_eng_we), 64'(0));
    check("idle_resp", 64'(o_response), 64'(8'h01));
    set_slices(8'h4C, 32'h1234_5678, 8'h11, 8'h48, 32'h0000_01AA, 8'h87);
    do_cmd("t3", 2'b01, 2'b01, 2'b01, 8'h4C, 32'h1234_5678, 8'h11, 10, 8'h00, 1'b1);

    // Fresh pointer, then both requesters held for four commands
    rst   = 1'b1;
    i_req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    set_slices(8'h51, 32'h0000_1000, 8'h21, 8'h58, 32'h0000_2000, 8'h33);
    do_cmd("t2a", 2'b11, 2'b11, 2'b01, 8'h51, 32'h0000_1000, 8'h21, 5, 8'h00, 1'b0);
    do_cmd("t2b", 2'b11, 2'b11, 2'b10, 8'h58, 32'h0000_2000, 8'h33, 5, 8'h01, 1'b0);
    do_cmd("t2c", 2'b11, 2'b11, 2'b01, 8'h51, 32'h0000_1000, 8'h21, 6, 8'h02, 1'b0);
    do_cmd("t2d", 2'b11, 2'b11, 2'b10, 8'h58, 32'h0000_2000, 8'h33, 7, 8'h03, 1'b0);

    // Requester 1 drops its request mid-command
    do_cmd("t6a", 2'b11, 2'b11, 2'b01, 8'h51, 32'h0000_1000, 8'h21, 4, 8'h06, 1'b0);
    do_cmd("t6b", 2'b11, 2'b01, 2'b10, 8'h58, 32'h0000_2000, 8'h33, 8, 8'h04, 1'b0);
    do_cmd("t6c", 2'b01, 2'b01, 2'b01, 8'h51, 32'h0000_1000, 8'h21, 4, 8'h07, 1'b0);

    // Reset while waiting on the engine
    i_req = 2'b10;
    @(negedge clk);
    check("t4_we",  64'(o_eng_we), 64'(1));
    check("t4_gnt", 64'(o_gnt),    64'(2'b10));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_gnt",  64'(o_gnt),      64'(0));
    check("t4_rst_we",   64'(o_eng_we),   64'(0));
    check("t4_rst_resp", 64'(o_response), 64'(8'hFF));
    check("t4_rst_done", 64'(o_done),     64'(0));
    check("t4_rst_cmd",  64'(o_eng_cmd),  64'(8'hFF));
    rst = 1'b0;
    do_cmd("t4n", 2'b10, 2'b10, 2'b10, 8'h58, 32'h0000_2000, 8'h33, 6, 8'h09, 1'b0);
    i_req = 2'b00;
    @(negedge clk);

`ifdef SDC_ARB_TIMEOUT_EN
    begin
      int cycles;
      i_req = 2'b01;
      @(negedge clk);
      check("t5_we", 64'(o_eng_we), 64'(1));
      cycles = 0;
      while (o_done == '0 && cycles < 200) begin
        @(negedge clk);
        cycles++;
      end
      check("t5_cycles",  64'(cycles),     64'(100));
      check("t5_done",    64'(o_done),     64'(2'b01));
      check("t5_timeout", 64'(o_timeout),  64'(1));
      check("t5_resp",    64'(o_response), 64'(8'hFF));
      i_req = 2'b00;
      @(negedge clk);
      check("t5_to_end", 64'(o_timeout), 64'(0));
      do_cmd("t5_tie", 2'b01, 2'b01, 2'b01, 8'h51, 32'h0000_1000, 8'h21, 100, 8'h05, 1'b0);
      i_req = 2'b00;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
